// File: rtl/kbd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | kbd_pkg : shared constants, parser encoding and scancode->ASCII LUT   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package kbd_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_BRK     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam logic [6:0] BLANK     = 7'h7F;

  // Set-2 scancodes of letters, digits and space; everything else is 00.
  function automatic logic [7:0] sc_to_ascii(input logic [7:0] sc);
    logic [7:0] a;
    case (sc)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  function automatic logic is_lower(input logic [7:0] a);
    return (a >= 8'h61) && (a <= 8'h7A);
  endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_hex7seg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | kbd_hex7seg : 4-bit nibble to active-low {g,f,e,d,c,b,a} segments     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module kbd_hex7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/kbd_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | kbd_scan_ctrl : PS/2 scancode parser, held-key tracker, 6-digit HEX   |
// | Optional macro KBD_SHIFT_EN: shift keys select uppercase letters.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module kbd_scan_ctrl #(
  parameter int         CNT_W = 8,
  parameter logic [6:0] BLANK = 7'h7F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_valid,
  output logic             ps2_ready,
  output logic [7:0]       key_code,
  output logic [7:0]       key_ascii,
  output logic             key_ext,
  output logic             key_active,
  output logic [CNT_W-1:0] press_cnt,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [6:0]       hex4,
  output logic [6:0]       hex5
);

  import kbd_pkg::*;

  logic [1:0]       r_state;
  logic [7:0]       r_byte;
  logic             r_rdy;
  logic             r_dec;
  logic [7:0]       r_key_code;
  logic [7:0]       r_key_ascii;
  logic             r_key_ext;
  logic             r_key_active;
  logic [CNT_W-1:0] r_press_cnt;

  logic [1:0]       w_state_nxt;
  logic             w_make;
  logic             w_brk;
  logic             w_ext;
  logic             w_match;
  logic             w_shift_code;
  logic [7:0]       w_ascii;
  logic [7:0]       w_cnt8;
  logic [23:0]      w_nibs;
  logic [6:0]       w_seg [6];

  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_ext       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_byte == SC_EXT)      w_state_nxt = S_EXT;
        else if (r_byte == SC_BRK) w_state_nxt = S_BRK;
        else                       w_make      = 1'b1;
      end
      S_EXT: begin
        if (r_byte == SC_BRK) begin
          w_state_nxt = S_EXT_BRK;
        end else if (r_byte != SC_EXT) begin
          w_make      = 1'b1;
          w_ext       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_BRK, S_EXT_BRK: begin
        // Stray prefixes inside a break sequence are swallowed.
        if ((r_byte != SC_EXT) && (r_byte != SC_BRK)) begin
          w_brk       = 1'b1;
          w_ext       = (r_state == S_EXT_BRK);
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_match = r_key_active && ({w_ext, r_byte} == {r_key_ext, r_key_code});

`ifdef KBD_SHIFT_EN
  logic r_shift;

  assign w_shift_code = (r_byte == SC_LSHIFT) || (r_byte == SC_RSHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= 1'b0;
    end else if (r_dec && w_shift_code) begin
      if (w_make)     r_shift <= 1'b1;
      else if (w_brk) r_shift <= 1'b0;
    end
  end

  always_comb begin
    w_ascii = w_ext ? 8'h00 : sc_to_ascii(r_byte);
    if (r_shift && is_lower(w_ascii)) w_ascii = w_ascii - 8'h20;
  end
`else
  assign w_shift_code = 1'b0;
  assign w_ascii      = w_ext ? 8'h00 : sc_to_ascii(r_byte);
`endif

  // One byte is accepted, then one decode cycle with ready low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_byte       <= 8'h00;
      r_rdy        <= 1'b0;
      r_dec        <= 1'b0;
      r_key_code   <= 8'h00;
      r_key_ascii  <= 8'h00;
      r_key_ext    <= 1'b0;
      r_key_active <= 1'b0;
      r_press_cnt  <= '0;
    end else if (r_dec) begin
      r_dec   <= 1'b0;
      r_rdy   <= 1'b1;
      r_state <= w_state_nxt;
      if (w_make && !w_shift_code && !w_match) begin
        r_key_code   <= r_byte;
        r_key_ext    <= w_ext;
        r_key_ascii  <= w_ascii;
        r_key_active <= 1'b1;
        r_press_cnt  <= r_press_cnt + CNT_W'(1);
      end
      if (w_brk && !w_shift_code && w_match) begin
        r_key_active <= 1'b0;
      end
    end else if (ps2_valid && r_rdy) begin
      r_byte <= ps2_data;
      r_rdy  <= 1'b0;
      r_dec  <= 1'b1;
    end else begin
      r_rdy <= 1'b1;
    end
  end

  generate
    if (CNT_W >= 8) begin : g_cnt_wide
      assign w_cnt8 = r_press_cnt[7:0];
    end else begin : g_cnt_narrow
      assign w_cnt8 = {{(8 - CNT_W){1'b0}}, r_press_cnt};
    end
  endgenerate

  assign w_nibs = {w_cnt8, r_key_ascii, r_key_code};

  generate
    for (genvar i = 0; i < 6; i++) begin : g_hex
      kbd_hex7seg u_seg (
        .nibble (w_nibs[4*i +: 4]),
        .seg    (w_seg[i])
      );
    end
  endgenerate

  assign ps2_ready  = r_rdy;
  assign key_code   = r_key_code;
  assign key_ascii  = r_key_ascii;
  assign key_ext    = r_key_ext;
  assign key_active = r_key_active;
  assign press_cnt  = r_press_cnt;

  assign hex0 = r_key_active ? w_seg[0] : BLANK;
  assign hex1 = r_key_active ? w_seg[1] : BLANK;
  assign hex2 = r_key_active ? w_seg[2] : BLANK;
  assign hex3 = r_key_active ? w_seg[3] : BLANK;
  assign hex4 = w_seg[4];
  assign hex5 = w_seg[5];

endmodule
`default_nettype wire

// File: tb/tb_kbd_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_kbd_scan_ctrl : scoreboard bench for kbd_scan_ctrl                 |
// | Honours KBD_SHIFT_EN when the DUT is built with it.                   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_kbd_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_valid = 1'b0;
  logic       ps2_ready;
  logic [7:0] key_code, key_ascii, press_cnt;
  logic       key_ext, key_active;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  kbd_scan_ctrl #(.CNT_W(8), .BLANK(7'h7F)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_data   (ps2_data),
    .ps2_valid  (ps2_valid),
    .ps2_ready  (ps2_ready),
    .key_code   (key_code),
    .key_ascii  (key_ascii),
    .key_ext    (key_ext),
    .key_active (key_active),
    .press_cnt  (press_cnt),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .hex4       (hex4),
    .hex5       (hex5)
  );

  always #5 clk = ~clk;

`ifdef KBD_SHIFT_EN
  localparam bit c_shift_en = 1'b1;
`else
  localparam bit c_shift_en = 1'b0;
`endif

  typedef struct {
    logic [7:0] code;
    logic [7:0] ascii;
    logic       ext;
    logic       act;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   pend    = 1'b0;

  logic [6:0] c_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0] c_let [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                             8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                             8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                             8'h35, 8'h1A};
  logic [7:0] c_dig [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                             8'h3E, 8'h46};

  // Reference model state
  int         m_st;
  logic [7:0] m_code, m_ascii, m_cnt;
  logic       m_ext, m_act, m_shift;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] b, input bit e, input bit sh);
    if (e) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (c_let[i] == b) return (sh ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (c_dig[i] == b) return 8'h30 + 8'(i);
    if (b == 8'h29) return 8'h20;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_st = 0; m_code = 0; m_ascii = 0; m_cnt = 0;
    m_ext = 0; m_act = 0; m_shift = 0;
  endtask

  task automatic model_make(input logic [7:0] b, input bit e);
    if (c_shift_en && (b == 8'h12 || b == 8'h59)) begin
      m_shift = 1'b1;
    end else if (!(m_act && m_code == b && m_ext == e)) begin
      m_code  = b;
      m_ext   = e;
      m_ascii = ref_ascii(b, e, m_shift);
      m_act   = 1'b1;
      m_cnt   = m_cnt + 8'd1;
    end
  endtask

  task automatic model_brk(input logic [7:0] b, input bit e);
    if (c_shift_en && (b == 8'h12 || b == 8'h59)) m_shift = 1'b0;
    else if (m_act && m_code == b && m_ext == e)  m_act = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] b);
    exp_t x;
    case (m_st)
      0: if (b == 8'hE0) m_st = 1;
         else if (b == 8'hF0) m_st = 2;
         else model_make(b, 1'b0);
      1: if (b == 8'hF0) m_st = 3;
         else if (b != 8'hE0) begin model_make(b, 1'b1); m_st = 0; end
      default: if (b != 8'hE0 && b != 8'hF0) begin
                 model_brk(b, m_st == 3); m_st = 0;
               end
    endcase
    x.code = m_code; x.ascii = m_ascii; x.ext = m_ext; x.act = m_act; x.cnt = m_cnt;
    sb.push_back(x);
  endtask

  task automatic compare_pop();
    exp_t x;
    check("sb_nonempty", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      x = sb.pop_front();
      check("key_code",   key_code,   x.code);
      check("key_ascii",  key_ascii,  x.ascii);
      check("key_ext",    key_ext,    x.ext);
      check("key_active", key_active, x.act);
      check("press_cnt",  press_cnt,  x.cnt);
      check("hex0", hex0, x.act ? c_seg[x.code[3:0]]  : 7'h7F);
      check("hex1", hex1, x.act ? c_seg[x.code[7:4]]  : 7'h7F);
      check("hex2", hex2, x.act ? c_seg[x.ascii[3:0]] : 7'h7F);
      check("hex3", hex3, x.act ? c_seg[x.ascii[7:4]] : 7'h7F);
      check("hex4", hex4, c_seg[x.cnt[3:0]]);
      check("hex5", hex5, c_seg[x.cnt[7:4]]);
    end
  endtask

  // Outputs are due two edges after the accepting edge.
  always @(posedge clk) begin
    logic acc;
    acc = rst && ps2_valid && ps2_ready;
    if (!rst) begin
      pend = 1'b0;
      sb.delete();
    end else if (pend) begin
      #1 compare_pop();
    end
    pend = acc;
  end

  task automatic send(input logic [7:0] b, input bit hold, input bit chk_gap);
    int n;
    n = 0;
    @(negedge clk);
    ps2_data  = b;
    ps2_valid = 1'b1;
    while (!ps2_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", ps2_ready, 1);
    if (chk_gap) check("b2b_gap", n, 1);
    if (ps2_ready) begin
      model_step(b);
      @(posedge clk);
      #1;
      check("ready_drop", ps2_ready, 0);
    end
    if (!hold) ps2_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_state();
    check("rst_ready",  ps2_ready,  0);
    check("rst_code",   key_code,   0);
    check("rst_ascii",  key_ascii,  0);
    check("rst_ext",    key_ext,    0);
    check("rst_active", key_active, 0);
    check("rst_cnt",    press_cnt,  0);
    check("rst_hex0", hex0, 7'h7F);
    check("rst_hex1", hex1, 7'h7F);
    check("rst_hex2", hex2, 7'h7F);
    check("rst_hex3", hex3, 7'h7F);
    check("rst_hex4", hex4, 7'h40);
    check("rst_hex5", hex5, 7'h40);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state();
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    do_reset();

    // Press and release 'a'
    send(8'h1C, 0, 0); send(8'hF0, 0, 0); send(8'h1C, 0, 0);
    settle();

    // Typematic repeats then a re-press
    send(8'h1C, 0, 0); send(8'h1C, 0, 0); send(8'h1C, 0, 0);
    send(8'hF0, 0, 0); send(8'h1C, 0, 0); send(8'h1C, 0, 0);
    settle();
    check("repress_cnt", press_cnt, 3);

    // Extended key, plain break must not release it
    send(8'hE0, 0, 0); send(8'h75, 0, 0); send(8'hF0, 0, 0); send(8'h75, 0, 0);
    settle();
    check("ext_held", key_active, 1);

    // Back-to-back alternating makes, counter wraps
    do_reset();
    for (int i = 0; i < 256; i++)
      send((i % 2 == 0) ? 8'h16 : 8'h1E, (i != 255), (i != 0));
    settle();
    check("wrap_cnt",  press_cnt, 0);
    check("wrap_hex5", hex5, 7'h40);
    check("wrap_hex4", hex4, 7'h40);

    // Reset mid-sequence drops the pending E0 prefix
    do_reset();
    send(8'hE0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready", ps2_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    send(8'h75, 0, 0);
    settle();
    check("midrst_ext", key_ext, 0);
    check("midrst_cnt", press_cnt, 1);

    do_reset();
`ifdef KBD_SHIFT_EN
    send(8'h12, 0, 0); send(8'h1C, 0, 0);
    settle();
    check("shift_upper", key_ascii, 8'h41);
    check("shift_cnt",   press_cnt, 1);
    send(8'hF0, 0, 0); send(8'h12, 0, 0);
    send(8'hF0, 0, 0); send(8'h1C, 0, 0); send(8'h1C, 0, 0);
    settle();
    check("shift_lower", key_ascii, 8'h61);
`else
    send(8'h12, 0, 0); send(8'h1C, 0, 0); send(8'h59, 0, 0);
    settle();
    check("noshift_cnt",   press_cnt, 3);
    check("noshift_ascii", key_ascii, 8'h00);
`endif

    settle();
    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kbd_scan_ctrl.md
Name: kbd_scan_ctrl

Overview:
- Sequences the PS/2 keyboard display path. Accepts raw scancode bytes from the PS/2 receiver over a valid/ready handshake and parses the make, break (F0) and extended (E0) prefixes.
- Tracks the currently held key, suppresses typematic repeats, and counts distinct presses.
- Maps the scancode to ASCII and drives six active-low seven-segment digits: code, ASCII, count.
- Sits between the PS/2 receiver and the board segment pins.

Parameters:
- CNT_W, 8, width of the press counter. Only the low 8 bits are displayed.
- BLANK, 7'h7F, segment pattern for a blanked digit.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- ps2_data  in  8  received scancode byte
- ps2_valid  in  1  ps2_data holds a new byte
- ps2_ready  out  1  controller can accept a byte this cycle
- key_code  out  8  scancode of the held key
- key_ascii  out  8  ASCII of the held key; 8'h00 if unmapped
- key_ext  out  1  held key was E0-prefixed
- key_active  out  1  a key is currently held
- press_cnt  out  CNT_W  distinct key presses, wraps
- hex0..hex5  out  7 each  segment patterns {g,f,e,d,c,b,a}, active-low
  - hex1:hex0 = key_code
  - hex3:hex2 = key_ascii
  - hex5:hex4 = press_cnt[7:0]

Behaviour:
- Reset: asynchronous, active-low on rst, clock clk. While rst is low:
  - all registers clear; ps2_ready=0; key_code=0, key_ascii=0, key_ext=0, key_active=0, press_cnt=0.
  - hex0..hex3 = BLANK; hex5/hex4 show "00" (7'h40 each).
  - Parser returns to S_IDLE.
- Handshake:
  - A byte transfers on a rising edge with ps2_valid && ps2_ready. It is latched into byte_q.
  - The next cycle is the decode cycle, with ps2_ready=0.
  - Outputs update at the end of the decode cycle, i.e. 2 edges after acceptance.
  - ps2_ready returns to 1 the cycle after decode. Maximum throughput is 1 byte per 2 cycles.
  - ps2_data is ignored when no transfer occurs.
- Parser FSM (states S_IDLE, S_EXT, S_BRK, S_EXT_BRK), evaluated in the decode cycle:
  - S_IDLE:
    - E0 -> S_EXT.
    - F0 -> S_BRK.
    - Other byte -> make event (ext=0), stay in S_IDLE.
  - S_EXT:
    - F0 -> S_EXT_BRK.
    - E0 -> stay.
    - Other byte -> make event (ext=1), go to S_IDLE.
  - S_BRK / S_EXT_BRK:
    - E0 or F0 -> ignored, stay.
    - Other byte -> break event (ext=0 for S_BRK, ext=1 for S_EXT_BRK), go to S_IDLE.
- Make event with id {ext,byte}:
  - If key_active and id == {key_ext,key_code}: typematic repeat, no state change.
  - Otherwise: key_code<=byte, key_ext<=ext, key_ascii<=lut(byte), key_active<=1, press_cnt<=press_cnt+1.
  - press_cnt wraps from all-ones to 0.
- Break event:
  - If id matches the held key: key_active<=0. key_code, key_ascii and key_ext retain their values.
  - Break of a non-held key: no effect.
- ASCII LUT:
  - Letters map to lowercase: 1C->61 'a', 32->62 ... 1A->7A.
  - Digits: 45,16,1E,26,25,2E,36,3D,3E,46 -> 30..39.
  - Space: 29->20.
  - Any extended key, and all other codes -> 00.
- Display:
  - hex0..hex3 = BLANK when key_active=0; otherwise the hex digits of key_code / key_ascii.
  - hex4/hex5 are always driven.
  - Hex-to-segment conversion is purely combinational from the registered values. No extra latency.

Optional Feature:
- KBD_SHIFT_EN defined:
  - Makes and breaks of 12 and 59 (left/right shift) set or clear a shift_held register.
  - Shift codes are neither counted nor displayed, and do not alter the held key.
  - While shift_held=1, a make of a letter key yields uppercase ASCII (lut-20h, e.g. 1C->41).
  - shift_held resets to 0.
- Undefined: 12 and 59 are ordinary keys (ASCII 00, counted).

Decomposition:
- Package kbd_pkg holds:
  - parser state encoding.
  - scancode constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59.
  - BLANK.
  - the scancode->ASCII LUT function.
- One sub-module: kbd_hex7seg (4-bit nibble -> 7-bit active-low segments), instantiated six times.

Test Plan:
- Bytes 1C, F0, 1C:
  - After 1C decode: key_code=1C, key_ascii=61, key_active=1, press_cnt=1, hex1/hex0=7'h79/7'h46.
  - After the break: key_active=0, hex0..hex3=7'h7F, press_cnt=1.
- Bytes 1C, 1C, 1C, F0, 1C, then 1C: press_cnt=1 after the repeats, then 2 after the re-press.
- Bytes E0, 75, F0, 75: key_ext=1, key_code=75, key_ascii=00, press_cnt+1; the plain break does not release; key_active stays 1.
- Alternate make 16/1E 256 times with ps2_valid held high:
  - ps2_ready toggles 1,0 each cycle.
  - press_cnt wraps to 00.
  - hex5/hex4 = 7'h40/7'h40.
- E0 accepted, rst pulsed low for 1 cycle, then 75: key_ext=0, press_cnt=1, ps2_ready=0 while rst is low.
- With KBD_SHIFT_EN, bytes 12, 1C: key_ascii=41, press_cnt=1. Then F0, 12, then F0, 1C, then 1C: key_ascii=61.
